// File: rtl/jtag_debug_sysclk_bridge_if.sv
// ---------------------------------------------------------------------------
// jtag_debug_sysclk_bridge_if
//
// Groups the JTAG-facing inputs and system-clock-domain command outputs of the
// debug bridge. The bridge itself connects through the slave modport; the
// agent driving JTAG strobes and consuming commands uses the master modport.
//
// Signals:
//   sr, ir_in, vs_udr, vs_uir  JTAG shift/instruction registers and update
//                              strobes (tck domain)
//   cmd_ack, overrun_clr       command consumer handshake / counter clear
//   jdo, ir_latched            captured shift register and instruction
//   take_action,
//   take_no_action             one-hot single-cycle command pulses
//   cmd_busy, overrun_cnt      handshake status and dropped-event count
// ---------------------------------------------------------------------------
interface jtag_debug_sysclk_bridge_if #(
    parameter int SR_WIDTH  = 38,
    parameter int IR_WIDTH  = 2,
    parameter int OVR_WIDTH = 4
);
    localparam int NUM_CMDS = 1 << IR_WIDTH;

    logic [SR_WIDTH-1:0]  sr;
    logic [IR_WIDTH-1:0]  ir_in;
    logic                 vs_udr;
    logic                 vs_uir;
    logic                 cmd_ack;
    logic                 overrun_clr;
    logic [SR_WIDTH-1:0]  jdo;
    logic [IR_WIDTH-1:0]  ir_latched;
    logic [NUM_CMDS-1:0]  take_action;
    logic [NUM_CMDS-1:0]  take_no_action;
    logic                 cmd_busy;
    logic [OVR_WIDTH-1:0] overrun_cnt;

    modport slave (
        input  sr, ir_in, vs_udr, vs_uir, cmd_ack, overrun_clr,
        output jdo, ir_latched, take_action, take_no_action, cmd_busy, overrun_cnt
    );

    modport master (
        output sr, ir_in, vs_udr, vs_uir, cmd_ack, overrun_clr,
        input  jdo, ir_latched, take_action, take_no_action, cmd_busy, overrun_cnt
    );
endinterface

// File: rtl/jtag_debug_sysclk_bridge.sv
// ---------------------------------------------------------------------------
// jtag_debug_sysclk_bridge
//
// System-clock half of the CPU debug module. Brings the tck-domain update-IR
// and update-DR strobes into the clk domain, captures the JTAG shift register
// into jdo on each accepted update-DR and issues a one-hot take_action or
// take_no_action pulse indexed by the current instruction. With ACK_MODE=1
// each command is held (cmd_busy) until cmd_ack; update-DR events arriving
// meanwhile are dropped and counted in a saturating overrun counter.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      jtag_debug_sysclk_bridge_if.slave (see interface for signals)
// ---------------------------------------------------------------------------
module jtag_debug_sysclk_bridge #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int ACT_BIT     = 37,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_MODE    = 0,
    parameter int OVR_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    jtag_debug_sysclk_bridge_if.slave     bus
);

    localparam int NUM_CMDS = 1 << IR_WIDTH;
    localparam logic [OVR_WIDTH-1:0] OVR_MAX = {OVR_WIDTH{1'b1}};

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic                   udr_edge_q, udr_edge_d;
    logic                   uir_edge_q, uir_edge_d;
    logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
    logic [IR_WIDTH-1:0]    ir_latched_q, ir_latched_d;
    logic [NUM_CMDS-1:0]    take_action_q, take_action_d;
    logic [NUM_CMDS-1:0]    take_no_action_q, take_no_action_d;
    logic [OVR_WIDTH-1:0]   overrun_cnt_q, overrun_cnt_d;

    logic                   udr_ev;
    logic                   uir_ev;
    logic                   accept;
    logic                   drop;
    logic [IR_WIDTH-1:0]    ir_dec;

    // Synchronisers and rising-edge detection. The chains reset to all-ones so
    // a strobe already high at reset release is not mistaken for a new edge.
    always_comb begin
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], bus.vs_udr};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], bus.vs_uir};
        udr_edge_d = udr_sync_q[SYNC_STAGES-1];
        uir_edge_d = uir_sync_q[SYNC_STAGES-1];
        udr_ev     = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
        uir_ev     = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;
    end

    // Command acceptance, decode and state machine.
    always_comb begin
        state_d          = state_q;
        jdo_d            = jdo_q;
        ir_latched_d     = ir_latched_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        overrun_cnt_d    = overrun_cnt_q;
        accept           = 1'b0;
        drop             = 1'b0;

        // An update-IR landing in the same cycle as update-DR decodes the
        // new instruction rather than the stale latched one.
        ir_dec = (uir_ev && udr_ev) ? bus.ir_in : ir_latched_q;

        if (uir_ev) begin
            ir_latched_d = bus.ir_in;
        end

        case (state_q)
            IDLE: begin
                accept = udr_ev;
                if (udr_ev && (ACK_MODE != 0)) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                accept = udr_ev && bus.cmd_ack;
                drop   = udr_ev && !bus.cmd_ack;
                if (bus.cmd_ack && !udr_ev) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            jdo_d = bus.sr;
            if (bus.sr[ACT_BIT]) begin
                take_action_d[ir_dec] = 1'b1;
            end else begin
                take_no_action_d[ir_dec] = 1'b1;
            end
        end

        // Clear wins over a simultaneous drop.
        if (bus.overrun_clr) begin
            overrun_cnt_d = '0;
        end else if (drop && (overrun_cnt_q != OVR_MAX)) begin
            overrun_cnt_d = overrun_cnt_q + OVR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            udr_sync_q       <= '1;
            uir_sync_q       <= '1;
            udr_edge_q       <= 1'b1;
            uir_edge_q       <= 1'b1;
            jdo_q            <= '0;
            ir_latched_q     <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overrun_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            udr_sync_q       <= udr_sync_d;
            uir_sync_q       <= uir_sync_d;
            udr_edge_q       <= udr_edge_d;
            uir_edge_q       <= uir_edge_d;
            jdo_q            <= jdo_d;
            ir_latched_q     <= ir_latched_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overrun_cnt_q    <= overrun_cnt_d;
        end
    end

    assign bus.jdo            = jdo_q;
    assign bus.ir_latched     = ir_latched_q;
    assign bus.take_action    = take_action_q;
    assign bus.take_no_action = take_no_action_q;
    assign bus.cmd_busy       = (state_q == WAIT_ACK);
    assign bus.overrun_cnt    = overrun_cnt_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge.sv
module tb_jtag_debug_sysclk_bridge;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_failed;

    // if0/u0: ACK_MODE=0, if1/u1: ACK_MODE=1
    jtag_debug_sysclk_bridge_if #(.SR_WIDTH(38), .IR_WIDTH(2), .OVR_WIDTH(4)) if0 ();
    jtag_debug_sysclk_bridge_if #(.SR_WIDTH(38), .IR_WIDTH(2), .OVR_WIDTH(4)) if1 ();

    jtag_debug_sysclk_bridge #(
        .SR_WIDTH(38), .IR_WIDTH(2), .ACT_BIT(37),
        .SYNC_STAGES(2), .ACK_MODE(0), .OVR_WIDTH(4)
    ) u0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0)
    );

    jtag_debug_sysclk_bridge #(
        .SR_WIDTH(38), .IR_WIDTH(2), .ACT_BIT(37),
        .SYNC_STAGES(2), .ACK_MODE(1), .OVR_WIDTH(4)
    ) u1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [3:0]  exp_ta;
        logic [3:0]  exp_tna;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_udr(input bit w, input logic v);
        if (w) if1.vs_udr = v; else if0.vs_udr = v;
    endtask

    task automatic set_uir(input bit w, input logic v);
        if (w) if1.vs_uir = v; else if0.vs_uir = v;
    endtask

    task automatic set_sr(input bit w, input logic [37:0] v);
        if (w) if1.sr = v; else if0.sr = v;
    endtask

    task automatic set_ir(input bit w, input logic [1:0] v);
        if (w) if1.ir_in = v; else if0.ir_in = v;
    endtask

    function automatic logic [3:0] get_ta(input bit w);
        return w ? if1.take_action : if0.take_action;
    endfunction

    function automatic logic [3:0] get_tna(input bit w);
        return w ? if1.take_no_action : if0.take_no_action;
    endfunction

    // Update-IR strobe carrying irv.
    task automatic uir_set(input bit w, input logic [1:0] irv);
        set_ir(w, irv);
        set_uir(w, 1'b1);
        repeat (3) tick();
        set_uir(w, 1'b0);
        repeat (3) tick();
    endtask

    // Raise vs_udr (optionally vs_uir too), hold 4 cycles, watch 8 cycles.
    // first = tick index at which a pulse was first seen (0 = none).
    task automatic issue(input bit w, input logic [37:0] srv, input bit with_uir,
                         output int first, output int cnt,
                         output logic [3:0] ta_or, output logic [3:0] tna_or);
        first  = 0;
        cnt    = 0;
        ta_or  = '0;
        tna_or = '0;
        set_sr(w, srv);
        set_udr(w, 1'b1);
        if (with_uir) set_uir(w, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if ((get_ta(w) | get_tna(w)) != 4'b0) begin
                if (first == 0) first = c;
                cnt++;
            end
            ta_or  = ta_or | get_ta(w);
            tna_or = tna_or | get_tna(w);
            if (c == 4) begin
                set_udr(w, 1'b0);
                if (with_uir) set_uir(w, 1'b0);
            end
        end
    endtask

    // Update-DR strobe on the ACK_MODE=1 instance; reports any pulse seen.
    task automatic udr_pulse1(input logic [37:0] srv, output logic [3:0] any);
        any = '0;
        if1.sr     = srv;
        if1.vs_udr = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            any = any | if1.take_action | if1.take_no_action;
            if (c == 2) if1.vs_udr = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          first;
        int          cnt;
        logic [3:0]  ta_or;
        logic [3:0]  tna_or;
        logic [3:0]  any;
        logic [37:0] sr_a;
        logic [37:0] sr_b;
        logic [37:0] sr_c;

        n_tests  = 0;
        n_failed = 0;

        vecs[0] = '{ir: 2'd2, sr: {1'b1, 5'h00, 32'hDEADBEEF}, exp_ta: 4'b0100, exp_tna: 4'b0000};
        vecs[1] = '{ir: 2'd1, sr: {1'b0, 5'h00, 32'hDEADBEEF}, exp_ta: 4'b0000, exp_tna: 4'b0010};
        vecs[2] = '{ir: 2'd0, sr: {1'b1, 5'h15, 32'hA5A50F0F}, exp_ta: 4'b0001, exp_tna: 4'b0000};
        vecs[3] = '{ir: 2'd3, sr: {1'b0, 5'h0A, 32'h12345678}, exp_ta: 4'b0000, exp_tna: 4'b1000};

        sr_a = {1'b1, 5'h00, 32'h11111111};
        sr_b = {1'b0, 5'h03, 32'hCAFE0001};
        sr_c = {1'b1, 5'h1F, 32'h0BADF00D};

        // Reset held with both strobes high.
        reset_n         = 1'b0;
        if0.sr          = 38'h2_0000_0001;
        if0.ir_in       = 2'd3;
        if0.vs_udr      = 1'b1;
        if0.vs_uir      = 1'b1;
        if0.cmd_ack     = 1'b0;
        if0.overrun_clr = 1'b0;
        if1.sr          = 38'h2_0000_0001;
        if1.ir_in       = 2'd3;
        if1.vs_udr      = 1'b1;
        if1.vs_uir      = 1'b0;
        if1.cmd_ack     = 1'b0;
        if1.overrun_clr = 1'b0;
        repeat (3) tick();
        chk("rst_jdo", if0.jdo, 38'h0);
        chk("rst_busy1", if1.cmd_busy, 1'b0);
        reset_n = 1'b1;
        any = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            any = any | if0.take_action | if0.take_no_action | if1.take_action | if1.take_no_action;
        end
        chk("rel_no_pulse", any, 4'b0);
        chk("rel_jdo0", if0.jdo, 38'h0);
        chk("rel_jdo1", if1.jdo, 38'h0);
        chk("rel_ir_latched", if0.ir_latched, 2'd0);
        chk("rel_overrun1", if1.overrun_cnt, 4'd0);
        if0.vs_udr = 1'b0;
        if0.vs_uir = 1'b0;
        if1.vs_udr = 1'b0;
        repeat (3) tick();

        // Table-driven commands on the ACK_MODE=0 instance.
        for (int i = 0; i < 4; i++) begin
            uir_set(1'b0, vecs[i].ir);
            chk($sformatf("v%0d_ir_latched", i), if0.ir_latched, vecs[i].ir);
            issue(1'b0, vecs[i].sr, 1'b0, first, cnt, ta_or, tna_or);
            chk($sformatf("v%0d_latency", i), first, 3);
            chk($sformatf("v%0d_width", i), cnt, 1);
            chk($sformatf("v%0d_ta", i), ta_or, vecs[i].exp_ta);
            chk($sformatf("v%0d_tna", i), tna_or, vecs[i].exp_tna);
            chk($sformatf("v%0d_jdo", i), if0.jdo, vecs[i].sr);
            chk($sformatf("v%0d_busy", i), if0.cmd_busy, 1'b0);
        end

        // ACK_MODE=1: issue, then three drops while busy.
        uir_set(1'b1, 2'd2);
        issue(1'b1, sr_a, 1'b0, first, cnt, ta_or, tna_or);
        chk("ack_first_latency", first, 3);
        chk("ack_first_ta", ta_or, 4'b0100);
        chk("ack_first_busy", if1.cmd_busy, 1'b1);
        any = '0;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] a;
            udr_pulse1({1'b1, 5'h00, 32'h0 + i}, a);
            any = any | a;
            chk($sformatf("ack_drop%0d_busy", i), if1.cmd_busy, 1'b1);
        end
        chk("ack_drop_no_pulse", any, 4'b0);
        chk("ack_drop_jdo_hold", if1.jdo, sr_a);
        chk("ack_overrun3", if1.overrun_cnt, 4'd3);
        if1.cmd_ack = 1'b1;
        tick();
        if1.cmd_ack = 1'b0;
        chk("ack_release_busy", if1.cmd_busy, 1'b0);
        chk("ack_release_no_pulse", if1.take_action | if1.take_no_action, 4'b0);

        // Second command, then 17 more drops (20 total) -> saturation.
        issue(1'b1, sr_b, 1'b0, first, cnt, ta_or, tna_or);
        chk("ack_b_tna", tna_or, 4'b0100);
        chk("ack_b_ta", ta_or, 4'b0000);
        for (int i = 0; i < 17; i++) begin
            udr_pulse1({1'b0, 5'h00, 32'h100 + i}, any);
        end
        chk("ovr_saturate", if1.overrun_cnt, 4'd15);
        chk("ovr_jdo_hold", if1.jdo, sr_b);

        // overrun_clr in the same cycle as a dropped event.
        if1.sr     = {1'b0, 5'h00, 32'h77777777};
        if1.vs_udr = 1'b1;
        tick();
        tick();
        if1.overrun_clr = 1'b1;
        tick();
        if1.overrun_clr = 1'b0;
        if1.vs_udr      = 1'b0;
        repeat (3) tick();
        chk("ovr_clr_priority", if1.overrun_cnt, 4'd0);
        udr_pulse1({1'b0, 5'h00, 32'h88888888}, any);
        chk("ovr_count_resume", if1.overrun_cnt, 4'd1);

        // cmd_ack coinciding with udr_ev accepts the new command and stays busy.
        if1.sr     = sr_c;
        if1.vs_udr = 1'b1;
        tick();
        tick();
        if1.cmd_ack = 1'b1;
        tick();
        if1.cmd_ack = 1'b0;
        chk("ackev_ta", if1.take_action, 4'b0100);
        chk("ackev_jdo", if1.jdo, sr_c);
        chk("ackev_busy", if1.cmd_busy, 1'b1);
        tick();
        chk("ackev_pulse_clear", if1.take_action, 4'b0000);
        chk("ackev_busy_hold", if1.cmd_busy, 1'b1);
        if1.vs_udr = 1'b0;
        repeat (3) tick();
        chk("ackev_overrun", if1.overrun_cnt, 4'd1);

        // Coincident update-IR and update-DR: the new IR wins.
        uir_set(1'b0, 2'd0);
        chk("coin_ir_before", if0.ir_latched, 2'd0);
        if0.ir_in = 2'd3;
        issue(1'b0, {1'b1, 5'h00, 32'h5555AAAA}, 1'b1, first, cnt, ta_or, tna_or);
        chk("coin_ta", ta_or, 4'b1000);
        chk("coin_latency", first, 3);
        chk("coin_ir_after", if0.ir_latched, 2'd3);

        // Reset asserted mid-WAIT_ACK with an update-DR in flight.
        if1.sr     = {1'b1, 5'h00, 32'h99999999};
        if1.vs_udr = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_jdo", if1.jdo, 38'h0);
        chk("midrst_ir", if1.ir_latched, 2'd0);
        chk("midrst_ta", if1.take_action, 4'b0);
        chk("midrst_tna", if1.take_no_action, 4'b0);
        chk("midrst_busy", if1.cmd_busy, 1'b0);
        chk("midrst_overrun", if1.overrun_cnt, 4'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        any = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            any = any | if1.take_action | if1.take_no_action;
        end
        chk("postrst_no_pulse", any, 4'b0);
        chk("postrst_busy", if1.cmd_busy, 1'b0);
        chk("postrst_jdo", if1.jdo, 38'h0);
        if1.vs_udr = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/jtag_debug_sysclk_bridge.md
Name: jtag_debug_sysclk_bridge

Overview:
- Parametrised successor to the CPU debug module's system-clock half.
- Synchronises the JTAG-domain update strobes (update-IR, update-DR) into the system clock domain and captures the shift register into jdo.
- Decodes the latched instruction into per-instruction take_action / take_no_action pulses.
- Adds beyond the previous generation: generalised IR/SR widths, optional acknowledge handshake, and a saturating overrun counter for commands dropped while busy.

Parameters:
SR_WIDTH, 38, width of sr and jdo
IR_WIDTH, 2, width of ir_in; NUM_CMDS = 2**IR_WIDTH
ACT_BIT, 37, index of sr bit selecting take_action (1) vs take_no_action (0)
SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir (legal 2..4)
ACK_MODE, 0, 1 = hold each issued command until cmd_ack
OVR_WIDTH, 4, overrun counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  SR_WIDTH  JTAG shift register contents, stable from vs_udr rise until next shift
ir_in  in  IR_WIDTH  JTAG instruction register, stable from vs_uir rise
vs_udr  in  1  update-DR strobe, tck domain, asynchronous to clk
vs_uir  in  1  update-IR strobe, tck domain, asynchronous to clk
cmd_ack  in  1  command consumed (used only when ACK_MODE=1)
overrun_clr  in  1  synchronous clear of overrun_cnt
jdo  out  SR_WIDTH  captured sr
ir_latched  out  IR_WIDTH  ir_in captured at last update-IR
take_action  out  NUM_CMDS  one-hot single-cycle pulse, index = decoded IR
take_no_action  out  NUM_CMDS  one-hot single-cycle pulse, index = decoded IR
cmd_busy  out  1  high in WAIT_ACK
overrun_cnt  out  OVR_WIDTH  saturating count of dropped update-DR events

Behaviour:
- Reset (asynchronous, reset_n low):
  - jdo, ir_latched, take_action, take_no_action, overrun_cnt all 0; cmd_busy 0; state IDLE.
  - Synchroniser chains and edge-detect registers reset to all-ones, so no event is generated at reset release whatever the input level.
  - Asserting reset mid-command aborts it; no pulse is issued afterwards.
- Synchronisers and event detection:
  - vs_udr and vs_uir each pass through SYNC_STAGES flops plus one edge-detect flop.
  - udr_ev / uir_ev = last sync stage high AND edge-detect flop low.
  - Each is a single-cycle rising-edge event; a level held high produces exactly one event.
- Update-IR:
  - On uir_ev, ir_latched <= ir_in at the next edge, in any state.
- IR used for decode (ir_dec):
  - ir_dec = ir_in when uir_ev and udr_ev coincide; otherwise ir_dec = ir_latched. The new IR wins.
- Update-DR accepted (udr_ev in IDLE, or in WAIT_ACK with cmd_ack high):
  - At the same edge: jdo <= sr.
  - If sr[ACT_BIT] = 1, take_action[ir_dec] <= 1; otherwise take_no_action[ir_dec] <= 1.
  - All other pulse bits are 0; pulses clear the following edge.
- Latency:
  - k = first clk edge sampling vs_udr high; S = SYNC_STAGES.
  - jdo and the pulse become valid after edge k+S and last one cycle (pulse only; jdo holds).
- State machine:
  - IDLE: an accepted udr_ev moves to WAIT_ACK if ACK_MODE=1, otherwise stays in IDLE.
  - WAIT_ACK:
    - cmd_busy = 1.
    - cmd_ack without udr_ev: go to IDLE.
    - cmd_ack with udr_ev: accept the new command and stay in WAIT_ACK.
    - udr_ev without cmd_ack: event dropped, jdo unchanged, overrun_cnt increments.
  - cmd_ack in IDLE is ignored.
  - ACK_MODE=0: WAIT_ACK is unreachable, cmd_busy stays 0, overrun_cnt stays 0.
- overrun_cnt:
  - Saturates at 2**OVR_WIDTH-1.
  - overrun_clr has priority over a simultaneous increment; the result is 0.
- ir_dec is always in range (2**IR_WIDTH entries); no out-of-range index exists.

Test Plan:
- Reset release with vs_udr held 1 and sr=38'h2_0000_0001 -> no pulse within 10 cycles; jdo=0; overrun_cnt=0.
- ACK_MODE=0, SYNC_STAGES=2: vs_uir rise with ir_in=2'b10, then vs_udr rise with sr[37]=1, sr[31:0]=32'hDEADBEEF -> ir_latched=2; after edge k+2, jdo[31:0]=32'hDEADBEEF and take_action=4'b0100 for exactly 1 cycle.
- Same as above with sr[37]=0 and ir_in=2'b01 -> take_no_action=4'b0010 for 1 cycle; take_action stays 0.
- ACK_MODE=1: first command issued, then 3 further vs_udr pulses before cmd_ack -> cmd_busy=1 throughout; jdo holds first sr; overrun_cnt=3; cmd_ack -> cmd_busy=0 next cycle.
- OVR_WIDTH=4, ACK_MODE=1: 20 dropped events -> overrun_cnt saturates at 15; overrun_clr coinciding with a drop -> 0.
- uir and udr events in the same cycle, ir_latched=0, ir_in=3, sr[37]=1 -> take_action=4'b1000; reset_n pulsed low mid-WAIT_ACK -> all outputs 0 immediately, state IDLE.
